// File: rtl/arb_pkg.sv
// Shared sizing, output-stage state type and small helpers for the request buffer.
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int CNT_W   = 2;
    localparam int IDX_W   = $clog2(NUM_REQ);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // True when more than one bit of the vector is set.
    function automatic logic multi_hot(input logic [NUM_REQ-1:0] v);
        return (v & (v - 1'b1)) != '0;
    endfunction

endpackage

// File: rtl/req_buffer8_if.sv
// Request/grant bundle between the buffer, its requesters, the priority selector and the consumer.
interface req_buffer8_if;
    import arb_pkg::*;

    logic [NUM_REQ-1:0] req_in;
    logic               en;
    logic [NUM_REQ-1:0] gnt;
    logic               out_ready;
    logic [NUM_REQ-1:0] req_pend;
    logic               arb_en;
    logic               grant_valid;
    logic [NUM_REQ-1:0] grant_onehot;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] overflow;
    logic               err;

    modport master (
        output req_in, en, gnt, out_ready,
        input  req_pend, arb_en, grant_valid, grant_onehot, grant_idx, overflow, err
    );

    modport slave (
        input  req_in, en, gnt, out_ready,
        output req_pend, arb_en, grant_valid, grant_onehot, grant_idx, overflow, err
    );

endinterface

// File: rtl/pend_cnt.sv
// Saturating pending-request counter for one requester, with a sticky dropped-request flag.
module pend_cnt
    import arb_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic req,
    input  logic take,
    input  logic freeze,
    output logic pending,
    output logic overflow
);

    logic [CNT_W-1:0] cnt;

    // A request arriving while saturated is lost unless a take frees a slot in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (req && !take && cnt == CNT_MAX) begin
                overflow <= 1'b1;
            end
            if (!freeze) begin
                if (req && !take && cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end else if (take && !req) begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    assign pending = (cnt != '0);

endmodule

// File: rtl/req_buffer8.sv
// Eight-way pending-request buffer feeding an external priority selector, with a
// one-deep registered grant stage that stalls on consumer backpressure.
module req_buffer8
    import arb_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    req_buffer8_if.slave  bus
);

    out_state_e         state;
    out_state_e         state_nx;
    logic [NUM_REQ-1:0] onehot_q;
    logic [NUM_REQ-1:0] onehot_nx;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_nx;
    logic [IDX_W-1:0]   gnt_idx;
    logic               err_q;
    logic               arb_en;
    logic               proto_err;
    logic               take;
    logic [NUM_REQ-1:0] take_vec;
    logic [NUM_REQ-1:0] pend_vec;
    logic [NUM_REQ-1:0] ovf_vec;

    assign arb_en    = bus.en && (state == OUT_EMPTY || bus.out_ready);
    assign proto_err = arb_en && (multi_hot(bus.gnt) || (bus.gnt & ~pend_vec) != '0);
    assign take      = arb_en && (bus.gnt != '0) && !proto_err;
    assign take_vec  = take ? bus.gnt : '0;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.gnt[i]) begin
                gnt_idx = i[IDX_W-1:0];
            end
        end
    end

    // A take always wins; otherwise a full stage drains only when the consumer is ready.
    always_comb begin
        state_nx  = state;
        onehot_nx = onehot_q;
        idx_nx    = idx_q;
        case (state)
            OUT_EMPTY: begin
                if (take) begin
                    state_nx  = OUT_FULL;
                    onehot_nx = bus.gnt;
                    idx_nx    = gnt_idx;
                end
            end
            OUT_FULL: begin
                if (take) begin
                    onehot_nx = bus.gnt;
                    idx_nx    = gnt_idx;
                end else if (bus.out_ready) begin
                    state_nx  = OUT_EMPTY;
                    onehot_nx = '0;
                    idx_nx    = '0;
                end
            end
            default: begin
                state_nx  = OUT_EMPTY;
                onehot_nx = '0;
                idx_nx    = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= OUT_EMPTY;
            onehot_q <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            onehot_q <= onehot_nx;
            idx_q    <= idx_nx;
            err_q    <= err_q | proto_err;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        pend_cnt u_pend_cnt (
            .clock    (clock),
            .reset    (reset),
            .req      (bus.req_in[g]),
            .take     (take_vec[g]),
            .freeze   (proto_err),
            .pending  (pend_vec[g]),
            .overflow (ovf_vec[g])
        );
    end

    assign bus.req_pend     = pend_vec;
    assign bus.arb_en       = arb_en;
    assign bus.grant_valid  = (state == OUT_FULL);
    assign bus.grant_onehot = onehot_q;
    assign bus.grant_idx    = idx_q;
    assign bus.overflow     = ovf_vec;
    assign bus.err          = err_q;

endmodule
